// File: rtl/payload_capture.sv
// Captures payload_length I/Q samples after each detect pulse into a FIFO and
// streams them out on valid/ready, tagging the final sample of each packet.
module payload_capture #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int MAX_LEN    = 1024
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] i_i,
  input  logic              detect_i,
  input  logic [15:0]       payload_length_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_r_o,
  output logic [DATA_W-1:0] out_i_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              len_err_o,
  output logic              overflow_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int ENTRY_W = 2 * DATA_W + 1;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic signed [15:0] MAX_LEN_S = 16'(MAX_LEN);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_next;
  logic             len_err;
  logic             len_err_next;
  logic             overflow;
  logic             overflow_next;

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             len_ok;
  logic             entry_last;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;

  assign len_ok = ($signed(payload_length_i) > 16'sd0) &&
                  ($signed(payload_length_i) <= MAX_LEN_S);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign push_req   = (state == CAPTURE) && valid_i;
  assign pop        = !fifo_empty && out_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign entry_last = (remaining == CNT_W'(1));

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    len_err_next   = len_err;
    overflow_next  = overflow;

    case (state)
      IDLE: begin
        if (detect_i) begin
          overflow_next = 1'b0;
          len_err_next  = !len_ok;
          if (len_ok) begin
            remaining_next = payload_length_i[CNT_W-1:0];
            state_next     = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (valid_i) begin
          remaining_next = remaining - CNT_W'(1);
          if (entry_last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (drop) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      len_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      len_err   <= len_err_next;
      overflow  <= overflow_next;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {entry_last, r_i, i_i};
    end
  end

  assign head        = mem[rd_ptr[ADDR_W-1:0]];
  assign out_valid_o = !fifo_empty;
  assign out_last_o  = head[ENTRY_W-1];
  assign out_r_o     = head[2*DATA_W-1:DATA_W];
  assign out_i_o     = head[DATA_W-1:0];

  assign busy_o     = (state == CAPTURE);
  assign done_o     = (state == DONE);
  assign len_err_o  = len_err;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_payload_capture.sv
// Directed bench for payload_capture: one task per scenario, inline checks.
module tb_payload_capture;

  logic        Clk;
  logic        rst;
  logic        valid_i;
  logic [15:0] r_i;
  logic [15:0] i_i;
  logic        detect_i;
  logic [15:0] payload_length_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_r_o;
  logic [15:0] out_i_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic        len_err_o;
  logic        overflow_o;

  int errors;
  int checks;

  logic [32:0] beats[$];

  payload_capture dut (
    .Clk              (Clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .r_i              (r_i),
    .i_i              (i_i),
    .detect_i         (detect_i),
    .payload_length_i (payload_length_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_r_o          (out_r_o),
    .out_i_o          (out_i_o),
    .out_last_o       (out_last_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .len_err_o        (len_err_o),
    .overflow_o       (overflow_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (rst && out_valid_o && out_ready_i) begin
      beats.push_back({out_last_o, out_r_o, out_i_o});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_detect(input logic [15:0] len);
    detect_i         = 1'b1;
    payload_length_i = len;
    tick();
    detect_i         = 1'b0;
  endtask

  // Drives one strobe; caller observes state right after the capturing edge.
  task automatic strobe(input logic [15:0] r, input logic [15:0] i);
    valid_i = 1'b1;
    r_i     = r;
    i_i     = i;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    checks++;
    if ({out_valid_o, out_r_o, out_i_o, out_last_o} !== 34'd0) begin
      errors++;
      $display("FAIL reset_head: got %0h want 0", {out_valid_o, out_r_o, out_i_o, out_last_o});
    end
    checks++;
    if ({busy_o, done_o, len_err_o, overflow_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, len_err_o, overflow_o});
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [32:0] exp;
    beats.delete();
    out_ready_i = 1'b1;
    pulse_detect(16'd3);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy_o);
    end
    idle(15);
    for (int k = 1; k <= 3; k++) begin
      strobe(16'(k), 16'(16'h0100 + k));
      if (k == 3) begin
        checks++;
        if ({done_o, busy_o} !== 2'b10) begin
          errors++;
          $display("FAIL basic_done_pulse: got done,busy=%b want 10", {done_o, busy_o});
        end
        tick();
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
          errors++;
          $display("FAIL basic_done_end: got done,busy=%b want 00", {done_o, busy_o});
        end
      end
      idle(15);
    end
    checks++;
    if (beats.size() !== 3) begin
      errors++;
      $display("FAIL basic_count: got %0d want 3", beats.size());
    end
    for (int k = 0; k < beats.size(); k++) begin
      exp = {(k == 2), 16'(k + 1), 16'(16'h0101 + k)};
      checks++;
      if (beats[k] !== exp) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h want %h", k, beats[k], exp);
      end
    end
  endtask

  task automatic test_len_err();
    logic [15:0] lens [3];
    lens[0] = 16'd0;
    lens[1] = 16'hFFFB;
    lens[2] = 16'd1025;
    beats.delete();
    for (int k = 0; k < 3; k++) begin
      pulse_detect(lens[k]);
      checks++;
      if ({len_err_o, busy_o} !== 2'b10) begin
        errors++;
        $display("FAIL len_err_%0d: got err,busy=%b want 10", k, {len_err_o, busy_o});
      end
      strobe(16'h7777, 16'h7777);
      idle(3);
    end
    checks++;
    if (out_valid_o !== 1'b0 || beats.size() !== 0) begin
      errors++;
      $display("FAIL len_err_nowrite: got valid=%b beats=%0d want 0,0", out_valid_o,
               beats.size());
    end
  endtask

  task automatic test_overflow();
    int lasts;
    logic [32:0] exp;
    beats.delete();
    out_ready_i = 1'b0;
    pulse_detect(16'd70);
    checks++;
    if (len_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_len_err_clear: got %b want 0", len_err_o);
    end
    for (int k = 1; k <= 70; k++) begin
      strobe(16'(k), 16'(16'h8000 | k));
      if (k == 64) begin
        checks++;
        if (overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_at64: got %b want 0", overflow_o);
        end
      end
      if (k == 65) begin
        checks++;
        if (overflow_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_at65: got %b want 1", overflow_o);
        end
      end
      if (k == 69) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_busy69: got %b want 1", busy_o);
        end
      end
      if (k == 70) begin
        checks++;
        if (done_o !== 1'b1) begin
          errors++;
          $display("FAIL ovf_done70: got %b want 1", done_o);
        end
      end
      idle(15);
    end
    checks++;
    if (beats.size() !== 0 || out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_held: got beats=%0d valid=%b want 0,1", beats.size(), out_valid_o);
    end
    out_ready_i = 1'b1;
    idle(80);
    checks++;
    if (beats.size() !== 64) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d want 64", beats.size());
    end
    lasts = 0;
    for (int k = 0; k < beats.size(); k++) begin
      exp = {1'b0, 16'(k + 1), 16'(16'h8000 | (k + 1))};
      if (beats[k][32]) lasts++;
      checks++;
      if (beats[k] !== exp) begin
        errors++;
        $display("FAIL ovf_beat%0d: got %h want %h", k, beats[k], exp);
      end
    end
    checks++;
    if (lasts !== 0) begin
      errors++;
      $display("FAIL ovf_no_last: got %0d want 0", lasts);
    end
  endtask

  task automatic test_same_cycle();
    logic [32:0] exp [2];
    beats.delete();
    out_ready_i      = 1'b1;
    detect_i         = 1'b1;
    payload_length_i = 16'd2;
    valid_i          = 1'b1;
    r_i              = 16'h0AAA;
    i_i              = 16'h0AAA;
    tick();
    detect_i = 1'b0;
    valid_i  = 1'b0;
    checks++;
    if ({busy_o, overflow_o} !== 2'b10) begin
      errors++;
      $display("FAIL same_start: got busy,ovf=%b want 10", {busy_o, overflow_o});
    end
    idle(15);
    strobe(16'h0B01, 16'hF001);
    idle(15);
    strobe(16'h0B02, 16'hF002);
    idle(15);
    exp[0] = {1'b0, 16'h0B01, 16'hF001};
    exp[1] = {1'b1, 16'h0B02, 16'hF002};
    checks++;
    if (beats.size() !== 2) begin
      errors++;
      $display("FAIL same_count: got %0d want 2", beats.size());
    end
    for (int k = 0; k < beats.size() && k < 2; k++) begin
      checks++;
      if (beats[k] !== exp[k]) begin
        errors++;
        $display("FAIL same_beat%0d: got %h want %h", k, beats[k], exp[k]);
      end
    end
  endtask

  task automatic test_redetect();
    beats.delete();
    out_ready_i = 1'b1;
    pulse_detect(16'd4);
    idle(15);
    strobe(16'h0D01, 16'h0001);
    idle(15);
    strobe(16'h0D02, 16'h0002);
    pulse_detect(16'd10);
    pulse_detect(16'd0);
    checks++;
    if ({busy_o, len_err_o} !== 2'b10) begin
      errors++;
      $display("FAIL redet_ignored: got busy,err=%b want 10", {busy_o, len_err_o});
    end
    idle(13);
    strobe(16'h0D03, 16'h0003);
    idle(15);
    strobe(16'h0D04, 16'h0004);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL redet_done: got %b want 1", done_o);
    end
    idle(15);
    checks++;
    if (beats.size() !== 4) begin
      errors++;
      $display("FAIL redet_count: got %0d want 4", beats.size());
    end else begin
      checks++;
      if (beats[3] !== {1'b1, 16'h0D04, 16'h0004} || beats[2][32] !== 1'b0) begin
        errors++;
        $display("FAIL redet_last: got %h,%h want last only on 0d04", beats[2], beats[3]);
      end
    end
  endtask

  task automatic test_async_reset();
    beats.delete();
    out_ready_i = 1'b0;
    pulse_detect(16'd5);
    idle(15);
    strobe(16'h0E01, 16'h1111);
    idle(15);
    strobe(16'h0E02, 16'h2222);
    checks++;
    if ({out_valid_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre: got valid,busy=%b want 11", {out_valid_o, busy_o});
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_r_o, out_i_o, out_last_o, busy_o, done_o, len_err_o, overflow_o}
        !== 38'd0) begin
      errors++;
      $display("FAIL arst_outputs: got %h want 0",
               {out_valid_o, out_r_o, out_i_o, out_last_o, busy_o, done_o, len_err_o,
                overflow_o});
    end
    #2;
    rst = 1'b1;
    idle(2);
    beats.delete();
    out_ready_i = 1'b1;
    pulse_detect(16'd1);
    idle(15);
    strobe(16'h0C01, 16'hC001);
    idle(15);
    checks++;
    if (beats.size() !== 1) begin
      errors++;
      $display("FAIL arst_count: got %0d want 1", beats.size());
    end else begin
      checks++;
      if (beats[0] !== {1'b1, 16'h0C01, 16'hC001}) begin
        errors++;
        $display("FAIL arst_beat: got %h want %h", beats[0], {1'b1, 16'h0C01, 16'hC001});
      end
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst              = 1'b0;
    valid_i          = 1'b0;
    r_i              = '0;
    i_i              = '0;
    detect_i         = 1'b0;
    payload_length_i = '0;
    out_ready_i      = 1'b0;
    test_reset();
    test_basic();
    test_len_err();
    test_overflow();
    test_same_cycle();
    test_redetect();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
